// File: rtl/sm_imem_pkg.sv
// Shared definitions for the instruction-ROM arbiter: ROM geometry defaults,
// the RISC-V NOP returned for out-of-range fetches, and a one-hot helper.
package sm_imem_pkg;

    localparam int          MAX_CORES        = 8;
    localparam int          DEFAULT_ROM_SIZE = 64;
    localparam int          DEFAULT_ROM_AW   = 6;
    localparam logic [31:0] RV_NOP           = 32'h00000013;

    // Position of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic int unsigned onehot_idx(input logic [MAX_CORES-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CORES; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sm_rr_arbiter.sv
// Round-robin grant logic. The search starts at rr_ptr and wraps; after a
// grant the pointer moves just past the winner so every requester gets a turn.
module sm_rr_arbiter
    import sm_imem_pkg::*;
#(
    parameter int N_CORES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CORES-1:0] req,
    output logic [N_CORES-1:0] gnt
);

    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] next_ptr;
    logic [PW:0]   idx;
    logic          found;

    // Find the first requester at or after rr_ptr; nothing is granted in reset.
    always_comb begin
        gnt      = '0;
        next_ptr = rr_ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N_CORES)) begin
                idx = idx - (PW+1)'(N_CORES);
            end
            if (!found && rst_n && req[idx[PW-1:0]]) begin
                found              = 1'b1;
                gnt[idx[PW-1:0]]   = 1'b1;
                next_ptr           = (idx == (PW+1)'(N_CORES-1)) ? '0 : PW'(idx + 1'b1);
            end
        end
    end

    // Advance the pointer past the winner; hold it on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/sm_imem_arbiter.sv
// Shares one combinational instruction ROM between N_CORES cores. One fetch is
// granted per cycle; its ROM word is registered and returned a cycle later.
// Optional macro SM_IMEM_BOUNDS_EN: out-of-range fetches return a NOP and set
// a sticky per-core err bit instead of wrapping the address.
module sm_imem_arbiter
    import sm_imem_pkg::*;
#(
    parameter int N_CORES  = 4,
    parameter int ROM_SIZE = DEFAULT_ROM_SIZE,
    parameter int ROM_AW   = DEFAULT_ROM_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CORES-1:0]   req_valid,
    input  logic [N_CORES*32-1:0] req_addr,
    output logic [N_CORES-1:0]   req_ready,
    output logic [N_CORES-1:0]   rsp_valid,
    output logic [31:0]          rsp_data,
`ifdef SM_IMEM_BOUNDS_EN
    output logic [N_CORES-1:0]   err,
`endif
    output logic [31:0]          mem_a,
    input  logic [31:0]          mem_rd
);

    logic [N_CORES-1:0] gnt;
    logic               any_gnt;
    int unsigned        g;
    logic [31:0]        sel_addr;
    logic [31:0]        rsp_word;
    logic               oob;

    sm_rr_arbiter #(
        .N_CORES (N_CORES)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    // Select the winner's address and form the ROM address and returned word.
    always_comb begin
        g        = onehot_idx(MAX_CORES'(gnt));
        sel_addr = req_addr[32*g +: 32];
        oob      = 1'b0;
        mem_a    = '0;
`ifdef SM_IMEM_BOUNDS_EN
        oob      = (sel_addr >= 32'(ROM_SIZE));
`endif
        if (any_gnt && !oob) begin
            mem_a = 32'(sel_addr[ROM_AW-1:0]);
        end
        rsp_word = oob ? RV_NOP : mem_rd;
    end

`ifndef SM_IMEM_BOUNDS_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^{sel_addr[31:ROM_AW], oob};
`endif

    // Register the response; data holds on idle cycles, valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (any_gnt) begin
            rsp_valid <= gnt;
            rsp_data  <= rsp_word;
        end else begin
            rsp_valid <= '0;
        end
    end

`ifdef SM_IMEM_BOUNDS_EN
    // Sticky per-core flag for fetches beyond the end of the ROM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= '0;
        end else if (any_gnt && oob) begin
            err <= err | gnt;
        end
    end
`endif

endmodule

// File: tb/tb_sm_imem_arbiter.sv
// Directed testbench for sm_imem_arbiter (N_CORES=4, ROM_SIZE=64).
module tb_sm_imem_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [31:0]  mem_a;
    logic [31:0]  mem_rd;
`ifdef SM_IMEM_BOUNDS_EN
    logic [3:0]   err;
`endif

    logic [31:0]  rom [64];
    int           compared;
    int           mismatched;

    sm_imem_arbiter #(
        .N_CORES  (4),
        .ROM_SIZE (64),
        .ROM_AW   (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
`ifdef SM_IMEM_BOUNDS_EN
        .err       (err),
`endif
        .mem_a     (mem_a),
        .mem_rd    (mem_rd)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational ROM model
    assign mem_rd = rom[mem_a[5:0]];

    // Drive one cycle of inputs just after the falling edge
    task automatic applyStimulus(input logic rst, input logic [3:0] v,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3);
        @(negedge clk);
        rst_n     = rst;
        req_valid = v;
        req_addr  = {a3, a2, a1, a0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check grant and ROM address in the current cycle, then the response after the edge
    task automatic checkCycle(input string tag, input logic [3:0] exp_ready, input logic [31:0] exp_a,
                              input logic [3:0] exp_rv, input logic [31:0] exp_data);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        checkOutput({tag, "_mema"}, mem_a, exp_a);
        @(posedge clk);
        #1;
        checkOutput({tag, "_rspv"}, 32'(rsp_valid), 32'(exp_rv));
        checkOutput({tag, "_rspd"}, rsp_data, exp_data);
    endtask

    logic [31:0] loop_data [5];

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'hdead0000 | 32'(i);
        end
        rom[0] = 32'h00500093;
        rom[1] = 32'h00a00113;
        rom[2] = 32'h002081b3;
        rom[3] = 32'h5ff1a303;
        loop_data[0] = 32'h00500093;
        loop_data[1] = 32'h00a00113;
        loop_data[2] = 32'h002081b3;
        loop_data[3] = 32'h5ff1a303;
        loop_data[4] = 32'h00500093;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;

        $display("[TB] reset with all cores requesting");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1111, 0, 1, 2, 3);
            checkCycle("reset", 4'b0000, 32'd0, 4'b0000, 32'd0);
        end

        $display("[TB] all cores requesting, round-robin from core 0");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'b1111, 0, 1, 2, 3);
            checkCycle("rr", 4'(1 << (i % 4)), 32'(i % 4), 4'(1 << (i % 4)), loop_data[i]);
        end

        $display("[TB] single core");
        applyStimulus(1'b1, 4'b0100, 0, 0, 3, 0);
        checkCycle("single", 4'b0100, 32'd3, 4'b0100, 32'h5ff1a303);

        $display("[TB] sparse requests");
        applyStimulus(1'b1, 4'b0010, 0, 0, 0, 0);
        checkCycle("core1", 4'b0010, 32'd0, 4'b0010, 32'h00500093);
        applyStimulus(1'b1, 4'b1010, 0, 2, 0, 1);
        checkCycle("sparse3", 4'b1000, 32'd1, 4'b1000, 32'h00a00113);
        applyStimulus(1'b1, 4'b1010, 0, 2, 0, 1);
        checkCycle("sparse1", 4'b0010, 32'd2, 4'b0010, 32'h002081b3);
        applyStimulus(1'b1, 4'b0000, 0, 0, 0, 0);
        checkCycle("idle", 4'b0000, 32'd0, 4'b0000, 32'h002081b3);
        applyStimulus(1'b1, 4'b1101, 1, 0, 0, 1);
        checkCycle("held", 4'b0100, 32'd0, 4'b0100, 32'h00500093);

        $display("[TB] address beyond ROM end");
        applyStimulus(1'b1, 4'b0001, 65, 0, 0, 0);
`ifdef SM_IMEM_BOUNDS_EN
        checkCycle("bounds", 4'b0001, 32'd0, 4'b0001, 32'h00000013);
        checkOutput("err_set", 32'(err), 32'h1);
`else
        checkCycle("wrap", 4'b0001, 32'd1, 4'b0001, 32'h00a00113);
`endif
        applyStimulus(1'b1, 4'b0010, 0, 5, 0, 0);
        checkCycle("after", 4'b0010, 32'd5, 4'b0010, 32'hdead0005);
`ifdef SM_IMEM_BOUNDS_EN
        checkOutput("err_sticky", 32'(err), 32'h1);
`endif

        $display("[TB] reset mid-flight");
        applyStimulus(1'b1, 4'b0010, 0, 2, 0, 0);
        checkCycle("inflight", 4'b0010, 32'd2, 4'b0010, 32'h002081b3);
        applyStimulus(1'b0, 4'b1010, 0, 2, 0, 1);
        checkCycle("midreset", 4'b0000, 32'd0, 4'b0000, 32'd0);
`ifdef SM_IMEM_BOUNDS_EN
        checkOutput("err_clr", 32'(err), 32'h0);
`endif
        applyStimulus(1'b1, 4'b1010, 0, 3, 0, 1);
        checkCycle("restart", 4'b0010, 32'd3, 4'b0010, 32'h5ff1a303);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
